uart_mem_sequencer: RTL and testbench
=====================================

# uart_mem_sequencer

Top-level controller that sequences the UART memory communication interface and the processor cores through one full job. It receives instruction memory, then data memory, starts the cores and waits for completion, then transmits data memory back on a button press. It owns the memory-port selection between the communication interface and the cores, and sets the address range the interface uses for each phase. It includes a run-cycle counter and a watchdog timeout.

## Interface
- MEM_ADDR_LENGTH, 12, memory address width
- CNT_WIDTH, 24, run-cycle counter width
- RUN_TIMEOUT, 24'hFF_FFFF, cycles in RUN before ERROR; must be < 2**CNT_WIDTH
- clk  in  1  system clock
- rstN  in  1  reset, asynchronous, active-low
- mem_received  in  1  1-cycle pulse from comm interface: rx range fully written
- mem_transmitted  in  1  1-cycle pulse from comm interface: tx range fully sent
- proc_done  in  1  level from cores: job finished
- txBtnN  in  1  synchronized transmit request, active-low level
- ins_end_addr, data_end_addr, data_tx_end_addr  in  MEM_ADDR_LENGTH each  last addresses per phase
- mem_sel  out  1  0 = instruction memory, 1 = data memory, routed to comm interface
- mem_owner  out  1  0 = comm interface drives selected memory port, 1 = cores
- rx_end_addr, tx_start_addr, tx_end_addr  out  MEM_ADDR_LENGTH each  range to comm interface
- toggle_addr_range  out  1  constant 1 (ranges always explicit)
- txStartN  out  1  active-low 1-cycle transmit start to comm interface
- proc_start  out  1  1-cycle core start pulse
- run_cycles  out  CNT_WIDTH  cycles spent in last RUN
- seq_state  out  3  current state encoding (LEDs/debug)
- error  out  1  watchdog fired

## Operation
- States: WAIT_INS(0), WAIT_DATA(1), START(2), RUN(3), READY(4), TX_START(5), TX_WAIT(6), ERROR(7).
- WAIT_INS: mem_sel=0, rx_end_addr=ins_end_addr; mem_received -> WAIT_DATA.
- WAIT_DATA: mem_sel=1, rx_end_addr=data_end_addr; mem_received -> START.
- START: proc_start=1, run counter cleared to 0; -> RUN unconditionally.
- RUN: counter increments each cycle. proc_done -> READY; run_cycles latches the counter. Counter == RUN_TIMEOUT-1 without proc_done -> ERROR. If both occur in the same cycle, proc_done wins.
- READY: txBtnN==0 -> TX_START.
- TX_START: txStartN=0, mem_sel=1, tx_start_addr=0, tx_end_addr=data_tx_end_addr; -> TX_WAIT.
- TX_WAIT: mem_transmitted -> WAIT_INS.
- ERROR: sticky; error=1; left only by reset.
- mem_owner=1 in START and RUN, 0 elsewhere. While mem_owner=1, comm-interface writes never reach memory.
- mem_received is ignored outside WAIT_INS/WAIT_DATA, and mem_transmitted outside TX_WAIT.
- Counter arithmetic is unsigned CNT_WIDTH and never wraps, because ERROR is reached first.

## Timing
- Reset values: WAIT_INS, mem_sel=0, mem_owner=0, txStartN=1, proc_start=0, run_cycles=0, error=0, seq_state=0, all address outputs = 0 except rx_end_addr=ins_end_addr (combinational from state).
- Reset asserted mid-operation returns to WAIT_INS immediately; run_cycles is cleared.
- proc_start, txStartN and mem_owner are registered: valid in the cycle the state is entered, with 1-cycle latency from the triggering input edge.
- The address outputs and mem_sel are combinational from the state.
- A pulse input is consumed on the clk edge where it is high. The next state is visible one cycle later.
- txBtnN held low after TX_START has no further effect until READY is re-entered.

## Structure
- Package seq_pkg: seq_state_t enum (3 bit, encodings above), MEM_SEL_INS/MEM_SEL_DATA, OWNER_COMM/OWNER_PROC constants.
- Sub-module run_timer: counter, clear, enable, timeout compare, and latch of the run_cycles value.
- The FSM lives in uart_mem_sequencer.

## Test plan
- Reset, then two mem_received pulses 10 cycles apart -> states 0->1->2->3. proc_start is high for exactly 1 cycle. mem_owner=1 from START onwards.
- proc_done 100 cycles after START -> READY, run_cycles=100, mem_owner=0.
- txBtnN low for 5 cycles in READY -> exactly one txStartN low cycle with tx_end_addr=data_tx_end_addr; mem_transmitted -> WAIT_INS.
- RUN_TIMEOUT=16 with no proc_done -> ERROR after 16 RUN cycles, error=1. Later pulses on all inputs cause no exit.
- mem_received during RUN and TX_WAIT -> no state change. proc_done and the timeout in the same cycle -> READY.
- rstN low in TX_WAIT, asynchronous to clk -> all outputs reach their reset values before the next clk edge.

Source files
------------

// File: rtl/uart_mem_sequencer_pkg.sv
// Shared types and constants for the UART memory job sequencer.
// Holds the state encoding, which is also exported on seq_state.
package seq_pkg;

  typedef enum logic [2:0] {
    WAIT_INS  = 3'd0,
    WAIT_DATA = 3'd1,
    START     = 3'd2,
    RUN       = 3'd3,
    READY     = 3'd4,
    TX_START  = 3'd5,
    TX_WAIT   = 3'd6,
    ERROR     = 3'd7
  } seq_state_t;

  localparam logic MEM_SEL_INS  = 1'b0;
  localparam logic MEM_SEL_DATA = 1'b1;
  localparam logic OWNER_COMM   = 1'b0;
  localparam logic OWNER_PROC   = 1'b1;

endpackage

// File: rtl/uart_mem_sequencer_run_timer.sv
// Run-cycle counter with watchdog compare and a latch that captures
// how many RUN cycles the finished job took.
module run_timer #(
  parameter int                   CNT_WIDTH   = 24,
  parameter logic [CNT_WIDTH-1:0] RUN_TIMEOUT = {CNT_WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 latch_i,
  output logic                 timeout_o,
  output logic [CNT_WIDTH-1:0] run_cycles_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = RUN_TIMEOUT - CNT_ONE;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;

  // The latched value includes the current RUN cycle, so it is the count of RUN cycles.
  always_comb begin
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + CNT_ONE;
    if (latch_i)       cycles_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q    <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
    end
  end

  assign timeout_o    = enable_i && (cnt_q == LAST_CNT);
  assign run_cycles_o = cycles_q;

endmodule

// File: rtl/uart_mem_sequencer.sv
// Job sequencer: load instruction and data memory over UART, run the cores,
// then send data memory back on a button press. Owns memory-port arbitration.
module uart_mem_sequencer
  import seq_pkg::*;
#(
  parameter int                   MEM_ADDR_LENGTH = 12,
  parameter int                   CNT_WIDTH       = 24,
  parameter logic [CNT_WIDTH-1:0] RUN_TIMEOUT     = 24'hFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       mem_received,
  input  logic                       mem_transmitted,
  input  logic                       proc_done,
  input  logic                       txBtnN,
  input  logic [MEM_ADDR_LENGTH-1:0] ins_end_addr,
  input  logic [MEM_ADDR_LENGTH-1:0] data_end_addr,
  input  logic [MEM_ADDR_LENGTH-1:0] data_tx_end_addr,
  output logic                       mem_sel,
  output logic                       mem_owner,
  output logic [MEM_ADDR_LENGTH-1:0] rx_end_addr,
  output logic [MEM_ADDR_LENGTH-1:0] tx_start_addr,
  output logic [MEM_ADDR_LENGTH-1:0] tx_end_addr,
  output logic                       toggle_addr_range,
  output logic                       txStartN,
  output logic                       proc_start,
  output logic [CNT_WIDTH-1:0]       run_cycles,
  output logic [2:0]                 seq_state,
  output logic                       error
);

  seq_state_t state_q, state_d;
  logic       proc_start_q, proc_start_d;
  logic       tx_start_n_q, tx_start_n_d;
  logic       mem_owner_q, mem_owner_d;
  logic       timeout;

  run_timer #(
    .CNT_WIDTH   (CNT_WIDTH),
    .RUN_TIMEOUT (RUN_TIMEOUT)
  ) u_run_timer (
    .clk          (clk),
    .rstN         (rstN),
    .clear_i      (state_q == START),
    .enable_i     (state_q == RUN),
    .latch_i      ((state_q == RUN) && proc_done),
    .timeout_o    (timeout),
    .run_cycles_o (run_cycles)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= WAIT_INS;
      proc_start_q <= 1'b0;
      tx_start_n_q <= 1'b1;
      mem_owner_q  <= OWNER_COMM;
    end else begin
      state_q      <= state_d;
      proc_start_q <= proc_start_d;
      tx_start_n_q <= tx_start_n_d;
      mem_owner_q  <= mem_owner_d;
    end
  end

  // proc_done has priority over the watchdog when both land in one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_INS:  if (mem_received)    state_d = WAIT_DATA;
      WAIT_DATA: if (mem_received)    state_d = START;
      START:                          state_d = RUN;
      RUN: begin
        if (proc_done)                state_d = READY;
        else if (timeout)             state_d = ERROR;
      end
      READY:     if (!txBtnN)         state_d = TX_START;
      TX_START:                       state_d = TX_WAIT;
      TX_WAIT:   if (mem_transmitted) state_d = WAIT_INS;
      ERROR:                          state_d = ERROR;
      default:                        state_d = ERROR;
    endcase
  end

  // Registered strobes are decoded from the next state so they line up with state entry.
  always_comb begin
    proc_start_d  = (state_d == START);
    tx_start_n_d  = (state_d != TX_START);
    mem_owner_d   = ((state_d == START) || (state_d == RUN)) ? OWNER_PROC : OWNER_COMM;
    mem_sel       = MEM_SEL_INS;
    rx_end_addr   = '0;
    tx_start_addr = '0;
    tx_end_addr   = '0;
    unique case (state_q)
      WAIT_INS:  rx_end_addr = ins_end_addr;
      WAIT_DATA: begin
        mem_sel     = MEM_SEL_DATA;
        rx_end_addr = data_end_addr;
      end
      TX_START, TX_WAIT: begin
        mem_sel     = MEM_SEL_DATA;
        tx_end_addr = data_tx_end_addr;
      end
      default: ;
    endcase
  end

  assign mem_owner         = mem_owner_q;
  assign proc_start        = proc_start_q;
  assign txStartN          = tx_start_n_q;
  assign toggle_addr_range = 1'b1;
  assign seq_state         = state_q;
  assign error             = (state_q == ERROR);

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Directed bench for uart_mem_sequencer: one instance with the default
// watchdog for the full job flow, one with a 16-cycle watchdog.
module tb_uart_mem_sequencer;

  localparam logic [11:0] INS_END  = 12'h0FF;
  localparam logic [11:0] DATA_END = 12'h1FF;
  localparam logic [11:0] TX_END   = 12'h17F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Instance A: default watchdog
  logic        rstN_a = 1'b0, rx_a = 1'b0, txd_a = 1'b0, done_a = 1'b0, btn_a = 1'b1;
  logic        sel_a, own_a, tog_a, txs_a, ps_a, err_a;
  logic [11:0] rxe_a, txsa_a, txe_a;
  logic [23:0] cyc_a;
  logic [2:0]  st_a;

  // Instance B: 16-cycle watchdog
  logic        rstN_b = 1'b0, rx_b = 1'b0, txd_b = 1'b0, done_b = 1'b0, btn_b = 1'b1;
  logic        sel_b, own_b, tog_b, txs_b, ps_b, err_b;
  logic [11:0] rxe_b, txsa_b, txe_b;
  logic [23:0] cyc_b;
  logic [2:0]  st_b;

  uart_mem_sequencer dut_a (
    .clk(clk), .rstN(rstN_a), .mem_received(rx_a), .mem_transmitted(txd_a),
    .proc_done(done_a), .txBtnN(btn_a), .ins_end_addr(INS_END),
    .data_end_addr(DATA_END), .data_tx_end_addr(TX_END), .mem_sel(sel_a),
    .mem_owner(own_a), .rx_end_addr(rxe_a), .tx_start_addr(txsa_a),
    .tx_end_addr(txe_a), .toggle_addr_range(tog_a), .txStartN(txs_a),
    .proc_start(ps_a), .run_cycles(cyc_a), .seq_state(st_a), .error(err_a)
  );

  uart_mem_sequencer #(.RUN_TIMEOUT(24'd16)) dut_b (
    .clk(clk), .rstN(rstN_b), .mem_received(rx_b), .mem_transmitted(txd_b),
    .proc_done(done_b), .txBtnN(btn_b), .ins_end_addr(INS_END),
    .data_end_addr(DATA_END), .data_tx_end_addr(TX_END), .mem_sel(sel_b),
    .mem_owner(own_b), .rx_end_addr(rxe_b), .tx_start_addr(txsa_b),
    .tx_end_addr(txe_b), .toggle_addr_range(tog_b), .txStartN(txs_b),
    .proc_start(ps_b), .run_cycles(cyc_b), .seq_state(st_b), .error(err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_rx_a();
    rx_a = 1'b1; tick(); rx_a = 1'b0;
  endtask

  task automatic pulse_rx_b();
    rx_b = 1'b1; tick(); rx_b = 1'b0;
  endtask

  int ps_seen;
  int txs_seen;

  initial begin
    // ---------------- reset values ----------------
    tick(); tick();
    check_eq("rst_state", st_a, 0);
    check_eq("rst_mem_sel", sel_a, 0);
    check_eq("rst_mem_owner", own_a, 0);
    check_eq("rst_txStartN", txs_a, 1);
    check_eq("rst_proc_start", ps_a, 0);
    check_eq("rst_run_cycles", cyc_a, 0);
    check_eq("rst_error", err_a, 0);
    check_eq("rst_rx_end", rxe_a, INS_END);
    check_eq("rst_tx_start", txsa_a, 0);
    check_eq("rst_tx_end", txe_a, 0);
    check_eq("rst_toggle", tog_a, 1);
    rstN_a = 1'b1;
    tick();
    check_eq("idle_state", st_a, 0);

    // ---------------- receive both memories ----------------
    pulse_rx_a();
    check_eq("wdata_state", st_a, 1);
    check_eq("wdata_mem_sel", sel_a, 1);
    check_eq("wdata_rx_end", rxe_a, DATA_END);
    check_eq("wdata_owner", own_a, 0);
    repeat (9) tick();
    check_eq("wdata_hold", st_a, 1);
    pulse_rx_a();
    check_eq("start_state", st_a, 2);
    check_eq("start_proc_start", ps_a, 1);
    check_eq("start_owner", own_a, 1);
    ps_seen = (ps_a === 1'b1) ? 1 : 0;

    // ---------------- RUN for 100 cycles ----------------
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (ps_a === 1'b1) ps_seen++;
      if (k == 1) begin
        check_eq("run_state", st_a, 3);
        check_eq("run_owner", own_a, 1);
      end
      if (k == 50) rx_a = 1'b1;
      if (k == 51) begin
        rx_a = 1'b0;
        check_eq("run_ignores_rx", st_a, 3);
      end
      if (k == 100) begin
        check_eq("run_owner_late", own_a, 1);
        done_a = 1'b1;
      end
    end
    tick();
    done_a = 1'b0;
    check_eq("proc_start_pulses", ps_seen, 1);
    check_eq("ready_state", st_a, 4);
    check_eq("ready_run_cycles", cyc_a, 100);
    check_eq("ready_owner", own_a, 0);
    repeat (3) tick();
    check_eq("ready_hold", st_a, 4);

    // ---------------- transmit ----------------
    btn_a = 1'b0;
    txs_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (txs_a === 1'b0) begin
        txs_seen++;
        check_eq("txs_state", st_a, 5);
        check_eq("txs_tx_end", txe_a, TX_END);
        check_eq("txs_tx_start", txsa_a, 0);
        check_eq("txs_mem_sel", sel_a, 1);
      end
    end
    btn_a = 1'b1;
    check_eq("txStartN_pulses", txs_seen, 1);
    check_eq("txwait_state", st_a, 6);
    pulse_rx_a();
    check_eq("txwait_ignores_rx", st_a, 6);
    txd_a = 1'b1; tick(); txd_a = 1'b0;
    check_eq("back_to_ins", st_a, 0);
    check_eq("back_rx_end", rxe_a, INS_END);
    check_eq("kept_run_cycles", cyc_a, 100);

    // ---------------- second job, async reset in TX_WAIT ----------------
    pulse_rx_a();
    pulse_rx_a();
    tick();
    check_eq("job2_run", st_a, 3);
    tick(); tick();
    done_a = 1'b1; tick(); done_a = 1'b0;
    check_eq("job2_ready", st_a, 4);
    check_eq("job2_run_cycles", cyc_a, 3);
    btn_a = 1'b0; tick(); btn_a = 1'b1;
    tick();
    check_eq("job2_txwait", st_a, 6);
    #2 rstN_a = 1'b0;
    #1;
    check_eq("arst_state", st_a, 0);
    check_eq("arst_txStartN", txs_a, 1);
    check_eq("arst_owner", own_a, 0);
    check_eq("arst_mem_sel", sel_a, 0);
    check_eq("arst_run_cycles", cyc_a, 0);
    check_eq("arst_tx_end", txe_a, 0);
    check_eq("arst_rx_end", rxe_a, INS_END);
    tick();
    rstN_a = 1'b1;

    // ---------------- watchdog on instance B ----------------
    rstN_b = 1'b1;
    tick();
    pulse_rx_b();
    pulse_rx_b();
    check_eq("b_start", st_b, 2);
    for (int k = 1; k <= 16; k++) tick();
    check_eq("b_run_last", st_b, 3);
    tick();
    check_eq("b_error_state", st_b, 7);
    check_eq("b_error_flag", err_b, 1);
    check_eq("b_error_owner", own_b, 0);
    rx_b = 1'b1; txd_b = 1'b1; done_b = 1'b1; btn_b = 1'b0;
    repeat (4) tick();
    rx_b = 1'b0; txd_b = 1'b0; done_b = 1'b0; btn_b = 1'b1;
    tick();
    check_eq("b_error_sticky", st_b, 7);
    check_eq("b_error_flag_sticky", err_b, 1);

    // ---------------- proc_done coincides with timeout ----------------
    rstN_b = 1'b0;
    tick();
    check_eq("b_rst_error", err_b, 0);
    rstN_b = 1'b1;
    tick();
    pulse_rx_b();
    pulse_rx_b();
    for (int k = 1; k <= 16; k++) tick();
    done_b = 1'b1; tick(); done_b = 1'b0;
    check_eq("b_tie_state", st_b, 4);
    check_eq("b_tie_run_cycles", cyc_b, 16);
    check_eq("b_tie_error", err_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
